// File: rtl/lda_line_engine.sv
`default_nettype none
// ============================================================================
// Module   : lda_line_engine
// Brief    : Bresenham line rasteriser. Accepts two endpoints and a colour,
//            emits one pixel write per cycle (holding on framebuffer stall)
//            and pulses o_done when the last pixel has been written.
// Revision : 1.0 - initial release
// ============================================================================
module lda_line_engine #(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int CW = 3
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [XW-1:0] i_x0,
    input  logic [XW-1:0] i_x1,
    input  logic [YW-1:0] i_y0,
    input  logic [YW-1:0] i_y1,
    input  logic [CW-1:0] i_color,
    input  logic          i_stall,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_plot,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [CW-1:0] o_color
);

    // Internal coordinate width covers both axes so the steep swap is lossless;
    // the error term gets two extra bits for sign and headroom.
    localparam int CORD = (XW > YW) ? XW : YW;
    localparam int EW   = CORD + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;

    // Endpoints as latched at i_start, zero-extended to the internal width
    logic [CORD-1:0]       r_lx0, r_ly0, r_lx1, r_ly1;
    logic [CW-1:0]         r_color;

    // Walking state of the rasteriser (in the possibly swapped frame)
    logic                  r_steep;
    logic                  r_yneg;
    logic [CORD-1:0]       r_x, r_y, r_xend;
    logic [CORD-1:0]       r_dx, r_dy;
    logic signed [EW-1:0]  r_err;

    // Registered outputs
    logic                  r_busy, r_done, r_plot;
    logic [XW-1:0]         r_ox;
    logic [YW-1:0]         r_oy;
    logic [CW-1:0]         r_ocolor;

    // Set-up terms derived from the latched endpoints
    logic [CORD-1:0]       w_adx, w_ady;
    logic                  w_steep, w_rev, w_yneg;
    logic [CORD-1:0]       w_ax0, w_ay0, w_ax1, w_ay1;
    logic [CORD-1:0]       w_bx0, w_by0, w_bx1, w_by1;
    logic [CORD-1:0]       w_dx, w_dy;
    logic signed [EW-1:0]  w_err_init;
    logic [XW-1:0]         w_init_ox;
    logic [YW-1:0]         w_init_oy;

    // Per-step terms derived from the walking state
    logic [CORD-1:0]       w_x_step, w_y_step;
    logic signed [EW-1:0]  w_err_add, w_err_step;
    logic                  w_hop;
    logic [XW-1:0]         w_step_ox;
    logic [YW-1:0]         w_step_oy;

    // Octant normalisation: make the line shallow and left-to-right
    always_comb begin
        w_adx   = (r_lx1 >= r_lx0) ? (r_lx1 - r_lx0) : (r_lx0 - r_lx1);
        w_ady   = (r_ly1 >= r_ly0) ? (r_ly1 - r_ly0) : (r_ly0 - r_ly1);
        w_steep = (w_ady > w_adx);

        w_ax0 = w_steep ? r_ly0 : r_lx0;
        w_ay0 = w_steep ? r_lx0 : r_ly0;
        w_ax1 = w_steep ? r_ly1 : r_lx1;
        w_ay1 = w_steep ? r_lx1 : r_ly1;

        w_rev = (w_ax0 > w_ax1);
        w_bx0 = w_rev ? w_ax1 : w_ax0;
        w_by0 = w_rev ? w_ay1 : w_ay0;
        w_bx1 = w_rev ? w_ax0 : w_ax1;
        w_by1 = w_rev ? w_ay0 : w_ay1;

        w_dx       = w_bx1 - w_bx0;
        w_dy       = (w_by1 >= w_by0) ? (w_by1 - w_by0) : (w_by0 - w_by1);
        w_yneg     = !(w_by0 < w_by1);
        w_err_init = -$signed({2'b00, (w_dx >> 1)});

        // First pixel, mapped back to screen axes
        w_init_ox = w_steep ? w_by0[XW-1:0] : w_bx0[XW-1:0];
        w_init_oy = w_steep ? w_bx0[YW-1:0] : w_by0[YW-1:0];
    end

    // One Bresenham step: advance x, accumulate error, hop y when it goes positive
    always_comb begin
        w_x_step   = r_x + CORD'(1);
        w_err_add  = r_err + $signed({2'b00, r_dy});
        w_hop      = !w_err_add[EW-1] && (w_err_add != '0);
        w_y_step   = r_y;
        w_err_step = w_err_add;
        if (w_hop) begin
            w_y_step   = r_yneg ? (r_y - CORD'(1)) : (r_y + CORD'(1));
            w_err_step = w_err_add - $signed({2'b00, r_dx});
        end
        w_step_ox = r_steep ? w_y_step[XW-1:0] : w_x_step[XW-1:0];
        w_step_oy = r_steep ? w_x_step[YW-1:0] : w_y_step[YW-1:0];
    end

    // Control FSM with registered pixel/strobe outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_lx0    <= '0;
            r_ly0    <= '0;
            r_lx1    <= '0;
            r_ly1    <= '0;
            r_color  <= '0;
            r_steep  <= 1'b0;
            r_yneg   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_xend   <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_plot   <= 1'b0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_ocolor <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_lx0   <= CORD'(i_x0);
                        r_ly0   <= CORD'(i_y0);
                        r_lx1   <= CORD'(i_x1);
                        r_ly1   <= CORD'(i_y1);
                        r_color <= i_color;
                        r_busy  <= 1'b1;
                        r_state <= S_INIT;
                    end
                end

                S_INIT: begin
                    r_steep  <= w_steep;
                    r_yneg   <= w_yneg;
                    r_x      <= w_bx0;
                    r_y      <= w_by0;
                    r_xend   <= w_bx1;
                    r_dx     <= w_dx;
                    r_dy     <= w_dy;
                    r_err    <= w_err_init;
                    r_plot   <= 1'b1;
                    r_ox     <= w_init_ox;
                    r_oy     <= w_init_oy;
                    r_ocolor <= r_color;
                    r_state  <= S_DRAW;
                end

                S_DRAW: begin
                    // A stall holds everything, including the presented pixel
                    if (!i_stall) begin
                        if (r_x != r_xend) begin
                            r_x   <= w_x_step;
                            r_y   <= w_y_step;
                            r_err <= w_err_step;
                            r_ox  <= w_step_ox;
                            r_oy  <= w_step_oy;
                        end else begin
                            r_plot   <= 1'b0;
                            r_ox     <= '0;
                            r_oy     <= '0;
                            r_ocolor <= '0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_plot  = r_plot;
    assign o_x     = r_ox;
    assign o_y     = r_oy;
    assign o_color = r_ocolor;

endmodule
`default_nettype wire

// File: doc/lda_line_engine.md
LDA_LINE_ENGINE -- requirements
Module: lda_line_engine

Interface
REQ-001 Parameter: XW, 9, x-coordinate width in bits.
REQ-002 Parameter: YW, 8, y-coordinate width in bits.
REQ-003 Parameter: CW, 3, colour width in bits.
REQ-004 Port: i_clk  in  1  clock; all state updates on its rising edge.
REQ-005 Port: i_reset  in  1  reset, asynchronous, active-high.
REQ-006 Port: i_start  in  1  single-cycle request to draw one line.
REQ-007 Port: i_x0 / i_x1  in  XW  start / end x.
REQ-008 Port: i_y0 / i_y1  in  YW  start / end y.
REQ-009 Port: i_color  in  CW  line colour.
REQ-010 Port: i_stall  in  1  framebuffer not ready; current pixel must be held.
REQ-011 Port: o_busy  out  1  high in every state except IDLE.
REQ-012 Port: o_done  out  1  one-cycle pulse when the line is complete.
REQ-013 Port: o_plot  out  1  pixel write strobe.
REQ-014 Port: o_x / o_y / o_color  out  XW / YW / CW  pixel address and colour; valid while o_plot is high, all zero otherwise.

Function
REQ-015 FSM states: IDLE, INIT, DRAW, DONE; reset state is IDLE.
REQ-016 IDLE: i_start=1 latches x0,y0,x1,y1 and colour, then goes to INIT; i_start in any other state is ignored.
REQ-017 INIT (1 cycle): steep = |y1-y0| > |x1-x0|; if steep, swap x with y in both points; then, if x0 > x1, swap the two endpoints; dx=x1-x0; dy=|y1-y0|; err = -floor(dx/2); ystep = +1 if y0<y1 else -1; x=x0, y=y0; go to DRAW.
REQ-018 Internal coordinates use max(XW,YW) bits; err is signed with max(XW,YW)+2 bits; no overflow is permitted.
REQ-019 DRAW: o_plot=1; (o_x,o_y) = (y,x) if steep else (x,y); o_color = latched colour.
REQ-020 DRAW with i_stall=1: all internal state is held, and o_plot and the pixel outputs stay stable.
REQ-021 DRAW with i_stall=0 and x != x1: x+=1; err+=dy; if the updated err > 0, then y+=ystep and err-=dx (same cycle).
REQ-022 DRAW with i_stall=0 and x == x1: go to DONE.
REQ-023 DONE (1 cycle): o_done=1, o_plot=0, then IDLE.
REQ-024 Pixel count = dx+1, emitted in increasing internal-x order; the point-line case (x0=x1, y0=y1) emits exactly one pixel.
REQ-025 Timing with no stalls: i_start sampled at edge 0; first o_plot in cycle 2; o_done in cycle dx+3; a new i_start is accepted in cycle dx+4.
REQ-026 Horizontal, vertical and 45-degree lines emit no gaps and no duplicate pixels.

Reset
REQ-027 i_reset=1 forces IDLE immediately, regardless of clock.
REQ-028 Under reset, o_busy, o_done, o_plot, o_x, o_y and o_color are 0.
REQ-029 Reset asserted mid-line aborts the line with no o_done pulse; internal registers are cleared to 0.
REQ-030 The first i_start after reset release is accepted normally.

Verification
REQ-031 Start (0,0)->(3,0), colour 5, no stall -> plots (0,0),(1,0),(2,0),(3,0) with colour 5 in cycles 2-5; o_done in cycle 6.
REQ-032 Steep line (0,0)->(1,3) -> plots (0,0),(0,1),(1,2),(1,3) in that order.
REQ-033 Reversed line (3,2)->(0,0) -> plots (0,0),(1,1),(2,1),(3,2); o_done in cycle 6.
REQ-034 Point line (5,5)->(5,5) -> one plot (5,5) in cycle 2; o_done in cycle 3; i_start pulsed in cycle 1 is ignored.
REQ-035 Line (0,0)->(3,0) with i_stall=1 during cycles 3-4 -> pixel (1,0) held through cycles 3-5; o_done in cycle 8; no pixel skipped or duplicated.
REQ-036 Reset asserted in cycle 3 of line (0,0)->(7,7) -> all outputs 0 at once, no o_done; a new i_start after release draws correctly.
